// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the XNOR LFSR stream b[n] = ~(b[n-WIDTH] ^ b[n-TAP]).
// Fills its history, verifies LOCK_N predictions, then flywheels and counts bit errors.
module lfsr_checker #(
   parameter int WIDTH  = 10,
   parameter int TAP    = 7,
   parameter int LOCK_N = 16,
   parameter int LOSS_N = 4,
   parameter int CNT_W  = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_enable,
   input  logic             i_din,
   input  logic             i_clear,
   output logic             o_locked,
   output logic             o_error,
   output logic [CNT_W-1:0] o_err_count
);

   localparam int FILL_W = $clog2(WIDTH + 1);
   localparam int RUN_W  = $clog2(LOCK_N + 1);
   localparam int LOSS_W = (LOSS_N > 0) ? $clog2(LOSS_N + 1) : 1;

   typedef enum logic [1:0] {
      S_FILL,
      S_VERIFY,
      S_LOCKED
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_hist;
   logic [FILL_W-1:0]  r_fill_cnt;
   logic [RUN_W-1:0]   r_run_cnt;
   logic [LOSS_W-1:0]  r_loss_cnt;
   logic               r_locked;
   logic               r_error;
   logic [CNT_W-1:0]   r_err_count;

   logic w_pred;
   logic w_mismatch;
   logic w_hist_ones;

   // r_hist[0] is the most recently accepted bit.
   assign w_pred      = ~(r_hist[WIDTH-1] ^ r_hist[TAP-1]);
   assign w_mismatch  = (i_din != w_pred);
   assign w_hist_ones = &r_hist;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_FILL;
         r_hist      <= '0;
         r_fill_cnt  <= '0;
         r_run_cnt   <= '0;
         r_loss_cnt  <= '0;
         r_locked    <= 1'b0;
         r_error     <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_error <= 1'b0;
         if (i_enable) begin
            case (r_state)
               S_FILL: begin
                  r_hist     <= {r_hist[WIDTH-2:0], i_din};
                  r_fill_cnt <= r_fill_cnt + 1'b1;
                  if (r_fill_cnt == FILL_W'(WIDTH - 1)) begin
                     r_state   <= S_VERIFY;
                     r_run_cnt <= '0;
                  end
               end
               S_VERIFY: begin
                  r_hist <= {r_hist[WIDTH-2:0], i_din};
                  // An all-ones history is the XNOR lock-up state and must never be trusted.
                  if (w_mismatch || w_hist_ones) begin
                     r_state    <= S_FILL;
                     r_fill_cnt <= '0;
                  end else if (r_run_cnt == RUN_W'(LOCK_N - 1)) begin
                     r_state    <= S_LOCKED;
                     r_locked   <= 1'b1;
                     r_loss_cnt <= '0;
                  end else begin
                     r_run_cnt <= r_run_cnt + 1'b1;
                  end
               end
               S_LOCKED: begin
                  // Flywheel: the prediction, not the line bit, feeds the history.
                  r_hist <= {r_hist[WIDTH-2:0], w_pred};
                  if (w_mismatch) begin
                     r_error <= 1'b1;
                     if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
                     if (LOSS_N > 0 && r_loss_cnt == LOSS_W'(LOSS_N - 1)) begin
                        r_state    <= S_FILL;
                        r_locked   <= 1'b0;
                        r_fill_cnt <= '0;
                        r_loss_cnt <= '0;
                     end else begin
                        r_loss_cnt <= r_loss_cnt + 1'b1;
                     end
                  end else begin
                     r_loss_cnt <= '0;
                  end
               end
               default: r_state <= S_FILL;
            endcase
         end
         // NOTE: the later non-blocking assignment wins, so Clear overrides a same-edge increment.
         if (i_clear) r_err_count <= '0;
      end
   end

   assign o_locked    = r_locked;
   assign o_error     = r_error;
   assign o_err_count = r_err_count;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: a default instance and a CNT_W=4 / LOSS_N=0 instance
// share the stimulus; expected outputs go through a scoreboard queue.
module tb_lfsr_checker;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        enable = 1'b0;
   logic        din    = 1'b0;
   logic        clear  = 1'b0;
   logic        m_locked, m_error;
   logic [15:0] m_cnt;
   logic        s_locked, s_error;
   logic [3:0]  s_cnt;

   int          checks = 0;
   int          errors = 0;
   logic [9:0]  g;
   bit          sel_s  = 1'b0;

   typedef struct packed {
      logic        locked;
      logic        error;
      logic [15:0] cnt;
   } exp_t;

   exp_t  sb[$];
   string tags[$];

   always #5 clk = ~clk;

   lfsr_checker dut_m (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_din(din), .i_clear(clear),
      .o_locked(m_locked), .o_error(m_error), .o_err_count(m_cnt)
   );

   lfsr_checker #(.CNT_W(4), .LOSS_N(0)) dut_s (
      .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_din(din), .i_clear(clear),
      .o_locked(s_locked), .o_error(s_error), .o_err_count(s_cnt)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Reference generator, seeded with an all-zero history.
   task automatic gen_bit(output logic b);
      b = ~(g[9] ^ g[6]);
      g = {g[8:0], b};
   endtask

   task automatic step(input logic en, input logic d, input logic clr, input logic e_locked,
                       input logic e_error, input int e_cnt, input string tag);
      exp_t  e;
      string t;
      @(negedge clk);
      enable = en;
      din    = d;
      clear  = clr;
      e.locked = e_locked;
      e.error  = e_error;
      e.cnt    = 16'(e_cnt);
      sb.push_back(e);
      tags.push_back(tag);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      t = tags.pop_front();
      if (sel_s) begin
         check({t, " locked"}, {15'd0, s_locked}, {15'd0, e.locked});
         check({t, " error"},  {15'd0, s_error},  {15'd0, e.error});
         check({t, " count"},  {12'd0, s_cnt},    e.cnt);
      end else begin
         check({t, " locked"}, {15'd0, m_locked}, {15'd0, e.locked});
         check({t, " error"},  {15'd0, m_error},  {15'd0, e.error});
         check({t, " count"},  m_cnt,             e.cnt);
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n  = 1'b0;
      enable = 1'b0;
      clear  = 1'b0;
      #1;
      check({tag, " rst m_locked"}, {15'd0, m_locked}, 16'd0);
      check({tag, " rst m_error"},  {15'd0, m_error},  16'd0);
      check({tag, " rst m_count"},  m_cnt,             16'd0);
      check({tag, " rst s_count"},  {12'd0, s_cnt},    16'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      g     = '0;
   endtask

   initial begin
      logic b;
      logic inv;
      int   cnt;
      int   e;

      // Clean stream: lock after the 26th bit, never an error.
      do_reset("t1");
      for (int n = 1; n <= 1000; n++) begin
         gen_bit(b);
         step(1'b1, b, 1'b0, n >= 26, 1'b0, 0, $sformatf("t1 bit%0d", n));
      end

      // Single flipped bit, then a burst of three shorter than LOSS_N.
      do_reset("t2");
      cnt = 0;
      for (int n = 1; n <= 300; n++) begin
         gen_bit(b);
         inv = (n == 100) || (n >= 200 && n <= 202);
         if (inv) cnt++;
         step(1'b1, b ^ inv, 1'b0, n >= 26, inv, cnt, $sformatf("t2 bit%0d", n));
      end

      // Inverted stream after lock: four errors drop lock, no relock.
      do_reset("t3");
      for (int n = 1; n <= 300; n++) begin
         gen_bit(b);
         inv = (n > 50);
         cnt = (n <= 50) ? 0 : ((n >= 54) ? 4 : n - 50);
         step(1'b1, b ^ inv, 1'b0, (n >= 26 && n <= 53), (n >= 51 && n <= 54), cnt,
              $sformatf("t3 bit%0d", n));
      end

      // Stuck-at-one line never locks.
      do_reset("t4");
      for (int n = 1; n <= 500; n++)
         step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, $sformatf("t4 bit%0d", n));

      // Enable alternating, garbage on idle cycles; mid-stream reset then relock.
      do_reset("t5");
      e = 0;
      for (int k = 1; k <= 80; k++) begin
         if (k % 2 == 1) begin
            gen_bit(b);
            e++;
            step(1'b1, b, 1'b0, e >= 26, 1'b0, 0, $sformatf("t5a cyc%0d", k));
         end else begin
            step(1'b0, 1'($urandom), 1'b0, e >= 26, 1'b0, 0, $sformatf("t5a idle%0d", k));
         end
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t5 midreset locked", {15'd0, m_locked}, 16'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      e = 0;
      for (int k = 1; k <= 60; k++) begin
         if (k % 2 == 1) begin
            gen_bit(b);
            e++;
            step(1'b1, b, 1'b0, e >= 26, 1'b0, 0, $sformatf("t5b cyc%0d", k));
         end else begin
            step(1'b0, 1'($urandom), 1'b0, e >= 26, 1'b0, 0, $sformatf("t5b idle%0d", k));
         end
      end

      // Small counter, loss disabled: saturation and Clear on a mismatch cycle.
      sel_s = 1'b1;
      do_reset("t6");
      for (int n = 1; n <= 70; n++) begin
         gen_bit(b);
         if (n <= 40)
            step(1'b1, b, 1'b0, n >= 26, 1'b0, 0, $sformatf("t6 bit%0d", n));
         else if (n <= 60)
            step(1'b1, ~b, 1'b0, 1'b1, 1'b1, (n - 40 > 15) ? 15 : n - 40,
                 $sformatf("t6 bit%0d", n));
         else if (n == 61)
            step(1'b1, ~b, 1'b1, 1'b1, 1'b1, 0, "t6 clear");
         else if (n == 62)
            step(1'b1, ~b, 1'b0, 1'b1, 1'b1, 1, "t6 after clear");
         else
            step(1'b1, b, 1'b0, 1'b1, 1'b0, 1, $sformatf("t6 bit%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Serial receiver/checker for the pseudo-random bit stream produced by the team's LFSR generator chain.
- Self-synchronises to the incoming stream, declares lock, then predicts each following bit and counts mismatches.
- Sits downstream of any link carrying LFSR data, for example the board-to-board test path or the randomised player input, and is used as a bit-error checker.

Parameters:
WIDTH, 10, LFSR length in bits; history register width.
TAP, 7, second feedback tap. Recurrence: b[n] = ~(b[n-WIDTH] ^ b[n-TAP]) (XNOR; the all-ones history is the lock-up state).
LOCK_N, 16, consecutive correct predictions required after the history fill before Locked asserts.
LOSS_N, 4, consecutive mismatches while locked that drop lock; 0 disables loss-of-lock.
CNT_W, 16, width of the error counter.

Ports:
Clock  input  1  single system clock, rising edge.
Reset  input  1  asynchronous, active-low reset.
Enable  input  1  Din is a valid stream bit this cycle.
Din  input  1  received serial bit.
Clear  input  1  synchronous clear of ErrCount.
Locked  output  1  registered; 1 while in LOCKED.
Error  output  1  registered one-cycle pulse per counted mismatch.
ErrCount  output  CNT_W  registered, saturating mismatch count.

Behaviour:
- Reset low, asynchronous: state = FILL, history = 0, all counters = 0, Locked = 0, Error = 0, ErrCount = 0. Takes effect immediately, including mid-operation. Normal operation resumes on the first rising edge after Reset goes high.
- Enable low: no state, history or counter change; Error = 0 on the next edge.
- Predicted bit p = ~(h[WIDTH-1] ^ h[TAP-1]), where h[0] is the most recent accepted bit.
- FILL:
  - Each enabled bit shifts Din into h and increments the fill counter.
  - After WIDTH bits, move to VERIFY and clear the run counter.
- VERIFY:
  - Each enabled bit shifts Din into h.
  - Din == p: increment the run counter.
  - Din != p, or h is all ones: go back to FILL with fill counter = 0. The history is kept, the bit is not counted, and Error stays 0.
  - When the run counter reaches LOCK_N: go to LOCKED, and Locked = 1 after that same edge.
  - Lock latency from reset is therefore WIDTH + LOCK_N enabled bits.
- LOCKED (flywheel mode):
  - h shifts in p, not Din, so one flipped line bit produces exactly one counted error.
  - Din != p: Error = 1 for one cycle, ErrCount increments (saturating at all ones), and the mismatch-run counter increments.
  - Din == p: the mismatch-run counter is cleared.
  - When the mismatch-run counter reaches LOSS_N (LOSS_N > 0): go to FILL, and Locked = 0 after that edge. The LOSS_N-th mismatch is itself counted.
- Errors are counted only in LOCKED. FILL and VERIFY never pulse Error.
- Clear: ErrCount = 0 on the next edge and takes priority over a same-cycle increment. Error still pulses for that mismatch. Lock state is unaffected.
- ErrCount holds at 2^CNT_W - 1 once reached; Error continues to pulse.

Test Plan:
1. Reset low for 3 cycles, then high; bench generator seeded 0, Enable = 1 every cycle, 1000 bits -> Locked = 1 exactly after the edge accepting bit 26; ErrCount = 0 and Error never 1 thereafter.
2. After lock, invert one bit (bit 100) -> single Error pulse on the following cycle, ErrCount = 1. Then invert bits 200-202 -> ErrCount = 4, Locked stays 1, and predictions realign with no further errors.
3. After lock, drive Din = ~generator continuously -> Error pulses on 4 consecutive cycles, ErrCount = 4, Locked = 0 after the 4th. The inverted stream never relocks, and ErrCount stays 4.
4. Din stuck at 1 from reset for 500 bits -> Locked never asserts, because the all-ones history is rejected in VERIFY; Error never 1.
5. Enable alternating 1/0 with a clean stream -> Locked asserts after the 26th enabled bit (about cycle 52). Error and state never change on Enable = 0 cycles. Assert Reset mid-stream -> Locked drops immediately, and relock takes 26 more enabled bits.
6. CNT_W = 4, LOSS_N = 0: lock, then drive 20 inverted bits -> ErrCount saturates at 15 while Error pulses 20 times. Clear is asserted on a mismatch cycle -> ErrCount = 0 next cycle, Error still 1.
